// File: rtl/axi_xbar_pkg.sv
// Purpose : shared types for the crossbar write path (route records, dispatch FSM states).
// Latency : n/a (types and constants only).
// Backpressure : n/a.
// Contents: AXI_LEN_W, SLV_W, route_t {slv, len}, wd_state_e {ST_IDLE, ST_BURST}.
package axi_xbar_pkg;

  localparam int AXI_LEN_W   = 8;
  localparam int NUM_SLV_MAX = 4;
  localparam int SLV_W       = $clog2(NUM_SLV_MAX);

  // One granted AW: which slave owns the burst and how many beats (minus one) it carries.
  typedef struct packed {
    logic [SLV_W-1:0]     slv;
    logic [AXI_LEN_W-1:0] len;
  } route_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } wd_state_e;

endpackage

// File: rtl/w_route_fifo.sv
// Purpose : ring buffer of granted AW routes, consumed in grant order by the W dispatcher.
// Latency : a push becomes visible at front_o/empty_o on the cycle after it is written.
// Backpressure : push_i while full_o is dropped; pop_i while empty_o is ignored.
// Ports   : ACLK, ARESETn (sync, active-low), push_i/push_dat_i, pop_i, front_o, full_o, empty_o.
module w_route_fifo
  import axi_xbar_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   ACLK,
  input  logic   ARESETn,
  input  logic   push_i,
  input  route_t push_dat_i,
  input  logic   pop_i,
  output route_t front_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  route_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               do_push;
  logic               do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign front_o = mem_q[rd_ptr_q];

  // Storage needs no reset: nothing reads it while the counter says empty.
  always_ff @(posedge ACLK) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/w_dispatch.sv
// Purpose : pops W beats from the master's W FIFO and steers them to the slave that won the AW, in grant order.
// Latency : route push -> first WVALID two edges later; back-to-back bursts leave with no bubble.
// Backpressure : WVALID held until WREADY of the selected slave; empty W FIFO drops WVALID and pauses the burst.
// Ports   : ACLK, ARESETn (sync, active-low); route_push/route_slv/route_len/route_full (AW grant queue);
//           fifo_empty/fifo_pop/front_W* (W FIFO front); WVALID_S/WREADY_S/WDATA_S/WSTRB_S/WLAST_S (slave W);
//           wlast_err (one-cycle pulse when the master's WLAST disagrees with the AWLEN-derived WLAST).
module w_dispatch
  import axi_xbar_pkg::*;
#(
  parameter int NUM_SLAVES  = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int STRB_WIDTH  = 4,
  parameter int ROUTE_DEPTH = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  input  logic                          route_push,
  input  logic [$clog2(NUM_SLAVES)-1:0] route_slv,
  input  logic [AXI_LEN_W-1:0]          route_len,
  output logic                          route_full,
  input  logic                          fifo_empty,
  output logic                          fifo_pop,
  input  logic [DATA_WIDTH-1:0]         front_WDATA,
  input  logic [STRB_WIDTH-1:0]         front_WSTRB,
  input  logic                          front_WLAST,
  output logic [NUM_SLAVES-1:0]         WVALID_S,
  input  logic [NUM_SLAVES-1:0]         WREADY_S,
  output logic [DATA_WIDTH-1:0]         WDATA_S,
  output logic [STRB_WIDTH-1:0]         WSTRB_S,
  output logic                          WLAST_S,
  output logic                          wlast_err
);

  wd_state_e             state_q;
  logic [SLV_W-1:0]      sel_q;
  logic [AXI_LEN_W-1:0]  cur_len_q;
  logic [AXI_LEN_W-1:0]  beat_cnt_q;
  logic                  wlast_err_q;

  route_t                route_in;
  route_t                q_front;
  logic                  q_full;
  logic                  q_empty;
  logic                  q_pop;

  logic                  in_burst;
  logic                  beat_vld;
  logic                  hs;
  logic                  last_beat;

  assign route_in = '{slv: route_slv, len: route_len};

  w_route_fifo #(
    .DEPTH(ROUTE_DEPTH)
  ) u_route_fifo (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .push_i    (route_push),
    .push_dat_i(route_in),
    .pop_i     (q_pop),
    .front_o   (q_front),
    .full_o    (q_full),
    .empty_o   (q_empty)
  );

  assign in_burst  = (state_q == ST_BURST);
  assign beat_vld  = in_burst & ~fifo_empty;
  assign hs        = beat_vld & WREADY_S[sel_q];
  assign last_beat = in_burst & (beat_cnt_q == cur_len_q);

  // Load the next route either from IDLE or on the final beat of the current burst,
  // so consecutive bursts run without an idle cycle between them.
  assign q_pop = ~q_empty & (~in_burst | (hs & last_beat));

  always_comb begin
    WVALID_S = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      WVALID_S[i] = beat_vld & (sel_q == SLV_W'(i));
    end
  end

  assign fifo_pop   = hs;
  assign WDATA_S    = front_WDATA;
  assign WSTRB_S    = front_WSTRB;
  assign WLAST_S    = last_beat;
  assign route_full = q_full;
  assign wlast_err  = wlast_err_q;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      cur_len_q   <= '0;
      beat_cnt_q  <= '0;
      wlast_err_q <= 1'b0;
    end else begin
      // The master's WLAST is only audited; burst length always comes from AWLEN.
      wlast_err_q <= hs & (front_WLAST != last_beat);
      if (q_pop) begin
        state_q    <= ST_BURST;
        sel_q      <= q_front.slv;
        cur_len_q  <= q_front.len;
        beat_cnt_q <= '0;
      end else if (hs & last_beat) begin
        state_q    <= ST_IDLE;
      end else if (hs) begin
        beat_cnt_q <= beat_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_w_dispatch.sv
module tb_w_dispatch;

  typedef struct {logic [1:0] slv; logic [7:0] len;} rt_t;
  typedef struct {logic [31:0] d; logic [3:0] s; logic l;} wd_t;
  typedef struct {logic [1:0] slv; logic [31:0] d; logic [3:0] s; logic l;} ob_t;
  typedef struct {logic [1:0] slv; logic [31:0] d; logic [3:0] s; logic fl; logic [3:0] ev; logic ee;} vec_t;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        route_push;
  logic [1:0]  route_slv;
  logic [7:0]  route_len;
  logic        route_full;
  logic        fifo_empty;
  logic        fifo_pop;
  logic [31:0] front_WDATA;
  logic [3:0]  front_WSTRB;
  logic        front_WLAST;
  logic [3:0]  WVALID_S;
  logic [3:0]  WREADY_S;
  logic [31:0] WDATA_S;
  logic [3:0]  WSTRB_S;
  logic        WLAST_S;
  logic        wlast_err;

  always #5 ACLK = ~ACLK;

  w_dispatch #(.NUM_SLAVES(4), .DATA_WIDTH(32), .STRB_WIDTH(4), .ROUTE_DEPTH(4)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .route_push(route_push), .route_slv(route_slv), .route_len(route_len), .route_full(route_full),
    .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
    .front_WDATA(front_WDATA), .front_WSTRB(front_WSTRB), .front_WLAST(front_WLAST),
    .WVALID_S(WVALID_S), .WREADY_S(WREADY_S), .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S),
    .WLAST_S(WLAST_S), .wlast_err(wlast_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Bench-side W FIFO contents, plus the reference record of everything offered to the DUT.
  wd_t wq[$];
  wd_t words_m[$];
  rt_t routes_m[$];
  ob_t obs[$];
  int  err_obs = 0;
  int  pop_cnt = 0;

  logic        prev_stall = 1'b0;
  logic [3:0]  prev_v;
  logic [31:0] prev_d;
  logic [3:0]  prev_s;
  logic        prev_l;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_front();
    fifo_empty = (wq.size() == 0);
    if (wq.size() > 0) begin
      front_WDATA = wq[0].d;
      front_WSTRB = wq[0].s;
      front_WLAST = wq[0].l;
    end else begin
      front_WDATA = '0;
      front_WSTRB = '0;
      front_WLAST = 1'b0;
    end
  endtask

  task automatic add_word(input logic [31:0] d, input logic [3:0] s, input logic l);
    wd_t w;
    w = '{d: d, s: s, l: l};
    wq.push_back(w);
    words_m.push_back(w);
    drive_front();
  endtask

  // Observe at the falling edge, then advance one rising edge and settle inputs #1 later.
  task automatic cycle();
    logic [3:0] hsv;
    logic       pop_s;
    wd_t        tmp;
    @(negedge ACLK);
    pop_s = 1'b0;
    if (ARESETn) begin
      hsv = WVALID_S & WREADY_S;
      chk("pop_vs_handshake", {63'd0, fifo_pop}, {63'd0, |hsv});
      if (prev_stall)
        chk("stall_hold", {WVALID_S, WDATA_S, WSTRB_S, WLAST_S}, {prev_v, prev_d, prev_s, prev_l});
      for (int i = 0; i < 4; i++)
        if (hsv[i]) obs.push_back('{slv: 2'(i), d: WDATA_S, s: WSTRB_S, l: WLAST_S});
      if (wlast_err) err_obs++;
      if (route_push && !route_full) routes_m.push_back('{slv: route_slv, len: route_len});
      pop_s = fifo_pop;
      if (fifo_pop) pop_cnt++;
      prev_stall = (|WVALID_S) && !(|hsv);
      prev_v = WVALID_S; prev_d = WDATA_S; prev_s = WSTRB_S; prev_l = WLAST_S;
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge ACLK);
    #1;
    if (pop_s && wq.size() > 0) tmp = wq.pop_front();
    drive_front();
  endtask

  task automatic push_route(input logic [1:0] s, input logic [7:0] l);
    route_push = 1'b1;
    route_slv  = s;
    route_len  = l;
    cycle();
    route_push = 1'b0;
  endtask

  task automatic clear_model();
    wq.delete(); words_m.delete(); routes_m.delete(); obs.delete();
    err_obs = 0; pop_cnt = 0; prev_stall = 1'b0;
    drive_front();
  endtask

  // Expected slave-side stream: each accepted route in order takes len+1 words in order;
  // WLAST sits on the final beat of each route; an error is due wherever the master's flag differs.
  task automatic compare_stream(input string tag, input bit rnd_ready, input int budget);
    ob_t ex[$];
    int  wi = 0;
    int  exp_err = 0;
    int  n;
    foreach (routes_m[r]) begin
      for (int k = 0; k <= int'(routes_m[r].len); k++) begin
        if (wi < words_m.size()) begin
          ex.push_back('{slv: routes_m[r].slv, d: words_m[wi].d, s: words_m[wi].s, l: (k == int'(routes_m[r].len))});
          if (words_m[wi].l != (k == int'(routes_m[r].len))) exp_err++;
          wi++;
        end
      end
    end
    for (int c = 0; c < budget && obs.size() < ex.size(); c++) begin
      if (rnd_ready) WREADY_S = 4'($urandom);
      cycle();
    end
    WREADY_S = 4'hF;
    cycle();
    cycle();
    chk({tag, "_beat_count"}, 64'(obs.size()), 64'(ex.size()));
    n = (obs.size() < ex.size()) ? obs.size() : ex.size();
    for (int i = 0; i < n; i++)
      chk({tag, "_beat"}, {obs[i].slv, obs[i].d, obs[i].s, obs[i].l}, {ex[i].slv, ex[i].d, ex[i].s, ex[i].l});
    chk({tag, "_wlast_err_count"}, 64'(err_obs), 64'(exp_err));
    chk({tag, "_w_fifo_drained"}, 64'(wq.size()), 64'd0);
    clear_model();
  endtask

  vec_t tbl[6];
  rt_t  rr[$];
  wd_t  rw[$];

  initial begin
    tbl[0] = '{slv: 2'd0, d: 32'h1111_0000, s: 4'hF, fl: 1'b1, ev: 4'b0001, ee: 1'b0};
    tbl[1] = '{slv: 2'd1, d: 32'hDEAD_BEEF, s: 4'h3, fl: 1'b1, ev: 4'b0010, ee: 1'b0};
    tbl[2] = '{slv: 2'd2, d: 32'h0000_0000, s: 4'h0, fl: 1'b1, ev: 4'b0100, ee: 1'b0};
    tbl[3] = '{slv: 2'd3, d: 32'hFFFF_FFFF, s: 4'hC, fl: 1'b0, ev: 4'b1000, ee: 1'b1};
    tbl[4] = '{slv: 2'd1, d: 32'h1234_5678, s: 4'h1, fl: 1'b0, ev: 4'b0010, ee: 1'b1};
    tbl[5] = '{slv: 2'd3, d: 32'hA5A5_5A5A, s: 4'hF, fl: 1'b1, ev: 4'b1000, ee: 1'b0};

    ARESETn = 1'b0; route_push = 1'b0; route_slv = '0; route_len = '0; WREADY_S = 4'hF;
    clear_model();
    // Data present during reset: WVALID must still be low.
    add_word(32'hCAFE_0000, 4'h5, 1'b1);
    cycle(); cycle();
    chk("rst_route_full", {63'd0, route_full}, 64'd0);
    chk("rst_fifo_pop",   {63'd0, fifo_pop},   64'd0);
    chk("rst_wvalid",     {60'd0, WVALID_S},   64'd0);
    chk("rst_wlast",      {63'd0, WLAST_S},    64'd0);
    chk("rst_wlast_err",  {63'd0, wlast_err},  64'd0);
    chk("rst_wdata_follows_front", {32'd0, WDATA_S}, 64'h0000_0000_CAFE_0000);
    ARESETn = 1'b1;
    clear_model();
    cycle();

    // Single beat, two edges from push to WVALID.
    add_word(32'hA5A5_0001, 4'hF, 1'b1);
    push_route(2'd1, 8'd0);
    chk("t1_no_early_valid", {60'd0, WVALID_S}, 64'd0);
    cycle();
    chk("t1_wvalid", {60'd0, WVALID_S}, 64'b0010);
    chk("t1_wlast",  {63'd0, WLAST_S},  64'd1);
    chk("t1_pop",    {63'd0, fifo_pop}, 64'd1);
    chk("t1_wdata",  {32'd0, WDATA_S},  64'hA5A5_0001);
    cycle();
    chk("t1_idle_wvalid", {60'd0, WVALID_S}, 64'd0);
    chk("t1_idle_pop",    {63'd0, fifo_pop}, 64'd0);
    chk("t1_wlast_err",   {63'd0, wlast_err}, 64'd0);
    compare_stream("t1", 1'b0, 20);

    // Table of single-beat bursts.
    for (int v = 0; v < 6; v++) begin
      add_word(tbl[v].d, tbl[v].s, tbl[v].fl);
      push_route(tbl[v].slv, 8'd0);
      cycle();
      chk("tbl_wvalid", {60'd0, WVALID_S}, {60'd0, tbl[v].ev});
      chk("tbl_wdata",  {32'd0, WDATA_S},  {32'd0, tbl[v].d});
      chk("tbl_wstrb",  {60'd0, WSTRB_S},  {60'd0, tbl[v].s});
      chk("tbl_wlast",  {63'd0, WLAST_S},  64'd1);
      cycle();
      chk("tbl_wlast_err", {63'd0, wlast_err}, {63'd0, tbl[v].ee});
      chk("tbl_back_idle", {60'd0, WVALID_S}, 64'd0);
    end
    compare_stream("tbl", 1'b0, 20);

    // Four beats with slave 2 stalling beat 2 for two cycles.
    for (int i = 0; i < 4; i++) add_word(32'h2000_0000 + 32'(i), 4'hF, (i == 3));
    push_route(2'd2, 8'd3);
    cycle();
    chk("t2_b1_wvalid", {60'd0, WVALID_S}, 64'b0100);
    chk("t2_b1_wlast",  {63'd0, WLAST_S},  64'd0);
    cycle();
    WREADY_S = 4'b1011;
    chk("t2_b2_wdata", {32'd0, WDATA_S}, 64'h2000_0001);
    cycle();
    chk("t2_stall1", {28'd0, WVALID_S, WDATA_S}, {28'd0, 4'b0100, 32'h2000_0001});
    cycle();
    chk("t2_stall2", {28'd0, WVALID_S, WDATA_S}, {28'd0, 4'b0100, 32'h2000_0001});
    WREADY_S = 4'hF;
    cycle();
    chk("t2_b3_wlast", {63'd0, WLAST_S}, 64'd0);
    cycle();
    chk("t2_b4_wlast", {32'd0, WDATA_S[31:0]} | {31'd0, WLAST_S, 32'd0}, 64'h1_2000_0003);
    cycle();
    chk("t2_pop_count", 64'(pop_cnt), 64'd4);
    compare_stream("t2", 1'b0, 20);

    // Back-to-back bursts with no bubble.
    add_word(32'h3000_0000, 4'hF, 1'b0);
    add_word(32'h3000_0001, 4'hF, 1'b1);
    add_word(32'h3000_0002, 4'hF, 1'b1);
    push_route(2'd0, 8'd1);
    chk("t3_p0", {60'd0, WVALID_S}, 64'd0);
    push_route(2'd3, 8'd0);
    chk("t3_p1", {59'd0, WVALID_S, WLAST_S}, {59'd0, 4'b0001, 1'b0});
    cycle();
    chk("t3_p2", {59'd0, WVALID_S, WLAST_S}, {59'd0, 4'b0001, 1'b1});
    cycle();
    chk("t3_p3_no_gap", {59'd0, WVALID_S, WLAST_S}, {59'd0, 4'b1000, 1'b1});
    cycle();
    chk("t3_p4", {60'd0, WVALID_S}, 64'd0);
    compare_stream("t3", 1'b0, 20);

    // Master WLAST early on beat 2: pulse after that beat, burst still four beats.
    for (int i = 0; i < 4; i++) add_word(32'h4000_0000 + 32'(i), 4'hF, (i == 1) || (i == 3));
    push_route(2'd1, 8'd3);
    cycle();
    cycle();
    chk("t4_no_err_yet", {63'd0, wlast_err}, 64'd0);
    cycle();
    chk("t4_err_pulse",  {63'd0, wlast_err}, 64'd1);
    cycle();
    chk("t4_err_clear",  {63'd0, wlast_err}, 64'd0);
    compare_stream("t4", 1'b0, 20);

    // Route queue fill: the first route moves straight into the FSM, so the queue
    // holds n-1 entries after n pushes and is full after the fifth.
    for (int n = 1; n <= 5; n++) begin
      push_route(2'(n), 8'd0);
      chk("t5_full_after_push", {63'd0, route_full}, {63'd0, (n - 1) == 4});
    end
    push_route(2'd2, 8'd3);
    chk("t5_full_after_drop", {63'd0, route_full}, 64'd1);
    add_word(32'h5000_0000, 4'hF, 1'b1);
    cycle();
    chk("t5_full_clears", {63'd0, route_full}, 64'd0);
    for (int i = 1; i < 5; i++) add_word(32'h5000_0000 + 32'(i), 4'hF, 1'b1);
    compare_stream("t5", 1'b0, 40);

    // Reset in the middle of an eight-beat burst with another route queued.
    for (int i = 0; i < 8; i++) add_word(32'h6000_0000 + 32'(i), 4'hF, (i == 7));
    push_route(2'd0, 8'd7);
    push_route(2'd2, 8'd0);
    cycle();
    ARESETn = 1'b0;
    cycle();
    chk("t6_rst_wvalid", {60'd0, WVALID_S}, 64'd0);
    chk("t6_rst_full",   {63'd0, route_full}, 64'd0);
    chk("t6_rst_pop",    {63'd0, fifo_pop}, 64'd0);
    chk("t6_rst_wlast",  {63'd0, WLAST_S}, 64'd0);
    ARESETn = 1'b1;
    clear_model();
    add_word(32'h6666_0000, 4'h9, 1'b1);
    cycle();
    cycle();
    chk("t6_queue_flushed", {60'd0, WVALID_S}, 64'd0);
    push_route(2'd3, 8'd0);
    compare_stream("t6", 1'b0, 20);

    // Randomised traffic: random routes, data arrival, WREADY and occasional bad WLAST.
    for (int r = 0; r < 40; r++) begin
      rr.push_back('{slv: 2'($urandom_range(0, 3)), len: 8'($urandom_range(0, 7))});
      for (int k = 0; k <= int'(rr[r].len); k++)
        rw.push_back('{d: $urandom, s: 4'($urandom), l: (k == int'(rr[r].len)) ^ ($urandom_range(0, 7) == 0)});
    end
    begin
      int ri = 0;
      int wi = 0;
      int c  = 0;
      while ((ri < rr.size() || wi < rw.size()) && c < 20000) begin
        if (ri < rr.size() && !route_full && $urandom_range(0, 1) == 1) begin
          route_push = 1'b1;
          route_slv  = rr[ri].slv;
          route_len  = rr[ri].len;
          ri++;
        end
        if (wi < rw.size() && $urandom_range(0, 1) == 1) begin
          add_word(rw[wi].d, rw[wi].s, rw[wi].l);
          wi++;
        end
        WREADY_S = 4'($urandom);
        cycle();
        route_push = 1'b0;
        c++;
      end
      chk("rnd_stimulus_done", {32'(ri), 32'(wi)}, {32'(rr.size()), 32'(rw.size())});
    end
    compare_stream("rnd", 1'b1, 5000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
